// File: rtl/mem_fifo_pkg.sv
// Shared defaults and width helpers for the 1R1W memory FIFO controller.
package mem_fifo_pkg;

  localparam int DEPTH_DEFAULT = 32;
  localparam int WIDTH_DEFAULT = 64;

  // Address width needed to index a memory of the given depth.
  function automatic int addr_w(input int depth);
    return $clog2(depth);
  endfunction

  // Level width: holds 0..depth+2 (memory plus in-flight read plus 2-entry buffer).
  function automatic int lvl_w(input int depth);
    return $clog2(depth + 3);
  endfunction

endpackage

// File: rtl/fifo_prefetch_buf.sv
// Two-entry first-word-fall-through buffer that absorbs the memory read latency.
module fifo_prefetch_buf
  import mem_fifo_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             cap_en,
  input  logic [WIDTH-1:0] cap_data,
  input  logic             pop,
  output logic [1:0]       buf_cnt,
  output logic [WIDTH-1:0] head_data
);

  logic [WIDTH-1:0] ent_q [2];
  logic [WIDTH-1:0] ent_d [2];
  logic             head_q, head_d;
  logic [1:0]       cnt_q, cnt_d;
  logic             tail;

  // Next state: capture into the tail slot, advance head on pop; clear wins over both.
  always_comb begin
    ent_d  = ent_q;
    head_d = head_q;
    cnt_d  = cnt_q;
    tail   = head_q ^ cnt_q[0];
    if (clr) begin
      head_d = 1'b0;
      cnt_d  = 2'd0;
    end else begin
      if (cap_en) ent_d[tail] = cap_data;
      head_d = head_q ^ pop;
      cnt_d  = cnt_q + {1'b0, cap_en} - {1'b0, pop};
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) ent_q[i] <= '0;
      head_q <= 1'b0;
      cnt_q  <= 2'd0;
    end else begin
      for (int i = 0; i < 2; i++) ent_q[i] <= ent_d[i];
      head_q <= head_d;
      cnt_q  <= cnt_d;
    end
  end

  assign buf_cnt   = cnt_q;
  assign head_data = ent_q[head_q];

  a_buf_cnt_max: assert property (@(posedge clk) disable iff (!rst_n) cnt_q <= 2'd2);

endmodule

// File: rtl/mem_1r1w_fifo_ctrl.sv
// FIFO controller around an external 1R1W sync-read memory, FWFT output via prefetch buffer.
module mem_1r1w_fifo_ctrl
  import mem_fifo_pkg::*;
#(
  parameter int DEPTH  = DEPTH_DEFAULT,
  parameter int WIDTH  = WIDTH_DEFAULT,
  parameter int ADDR_W = addr_w(DEPTH),
  parameter int LVL_W  = lvl_w(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out_data,
  output logic [LVL_W-1:0]  level,
  output logic [ADDR_W-1:0] W0_addr,
  output logic              W0_en,
  output logic [WIDTH-1:0]  W0_data,
  output logic [ADDR_W-1:0] R0_addr,
  output logic              R0_en,
  input  logic [WIDTH-1:0]  R0_data
);

  localparam int CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [ADDR_W-1:0] wptr_q, wptr_d;
  logic [ADDR_W-1:0] rptr_q, rptr_d;
  logic [CNT_W-1:0]  mem_cnt_q, mem_cnt_d;
  logic              rd_inflight_q, rd_inflight_d;
  logic [1:0]        buf_cnt;
  logic [2:0]        pending;
  logic              push, pop, issue;

  // Handshakes and read issue; in_ready is held low while reset is asserted.
  always_comb begin
    in_ready  = rst_n & (mem_cnt_q != FULL_CNT) & ~flush;
    push      = in_valid & in_ready;
    out_valid = (buf_cnt != 2'd0);
    pop       = out_valid & out_ready & ~flush;
    pending   = 3'(buf_cnt) + 3'(rd_inflight_q);
    // Issue only if the returning word will have a buffer slot (pop frees one this cycle).
    issue     = (mem_cnt_q != '0) & (pending < (3'd2 + 3'(pop))) & ~flush;
  end

  // Pointer and count next state; flush clears everything.
  always_comb begin
    wptr_d        = wptr_q + ADDR_W'(push);
    rptr_d        = rptr_q + ADDR_W'(issue);
    mem_cnt_d     = mem_cnt_q + CNT_W'(push) - CNT_W'(issue);
    rd_inflight_d = issue;
    if (flush) begin
      wptr_d        = '0;
      rptr_d        = '0;
      mem_cnt_d     = '0;
      rd_inflight_d = 1'b0;
    end
  end

  // Control state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q        <= '0;
      rptr_q        <= '0;
      mem_cnt_q     <= '0;
      rd_inflight_q <= 1'b0;
    end else begin
      wptr_q        <= wptr_d;
      rptr_q        <= rptr_d;
      mem_cnt_q     <= mem_cnt_d;
      rd_inflight_q <= rd_inflight_d;
    end
  end

  assign W0_en   = push;
  assign W0_addr = wptr_q;
  assign W0_data = in_data;
  assign R0_en   = issue;
  assign R0_addr = rptr_q;

  // Level is derived from registered state only.
  assign level = LVL_W'(mem_cnt_q) + LVL_W'(rd_inflight_q) + LVL_W'(buf_cnt);

  // A read returning during flush is dropped by the buffer clear.
  fifo_prefetch_buf #(.WIDTH(WIDTH)) u_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (flush),
    .cap_en    (rd_inflight_q),
    .cap_data  (R0_data),
    .pop       (pop),
    .buf_cnt   (buf_cnt),
    .head_data (out_data)
  );

  a_mem_cnt_max: assert property (@(posedge clk) disable iff (!rst_n) mem_cnt_q <= FULL_CNT);

endmodule

// File: tb/tb_mem_1r1w_fifo_ctrl.sv
// Self-checking bench: memory model, per-cycle scoreboard, vector table and corner sequences.
module tb_mem_1r1w_fifo_ctrl;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, out_ready;
  logic        in_ready, out_valid, W0_en, R0_en;
  logic [63:0] in_data, out_data, W0_data, R0_data;
  logic [5:0]  level;
  logic [4:0]  W0_addr, R0_addr;

  mem_1r1w_fifo_ctrl dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .level(level),
    .W0_addr(W0_addr), .W0_en(W0_en), .W0_data(W0_data),
    .R0_addr(R0_addr), .R0_en(R0_en), .R0_data(R0_data)
  );

  always #5 clk = ~clk;

  // External 32x64 memory, read latency 1.
  logic [63:0] mem_model [32];
  always @(posedge clk) begin
    if (R0_en) R0_data <= mem_model[R0_addr];
    if (W0_en) mem_model[W0_addr] <= W0_data;
  end

  int checks = 0;
  int errors = 0;
  logic [63:0] sb_q[$];
  int wexp = 0;
  int rexp = 0;

  typedef struct {
    bit iv; logic [63:0] din;
    bit e_ovld; logic [63:0] e_odata; int e_lvl;
    bit e_wen; int e_waddr; bit e_ren; int e_raddr;
  } vec_t;
  vec_t tbl[11];

  function automatic vec_t mkv(int iv, logic [63:0] din, int ovld, logic [63:0] odata,
                               int lvl, int wen, int waddr, int ren, int raddr);
    vec_t v;
    v.iv = (iv != 0); v.din = din; v.e_ovld = (ovld != 0); v.e_odata = odata;
    v.e_lvl = lvl; v.e_wen = (wen != 0); v.e_waddr = waddr; v.e_ren = (ren != 0);
    v.e_raddr = raddr;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // One clock: drive at negedge, sample 1ns later, run the scoreboard.
  task automatic cycle(input bit iv, input bit ordy, input bit fl, input logic [63:0] d);
    logic [63:0] exp_word;
    @(negedge clk);
    in_valid = iv; out_ready = ordy; flush = fl; in_data = d;
    #1;
    chk("level_vs_model", 64'(level), 64'(sb_q.size()));
    chk("level_max", 64'(level > 6'd34), 64'd0);
    if (W0_en && R0_en) chk("addr_collision", 64'(R0_addr == W0_addr), 64'd0);
    if (W0_en) begin
      chk("w0_addr", 64'(W0_addr), 64'(wexp));
      chk("w0_data", W0_data, d);
      wexp = (wexp + 1) & 31;
    end
    if (R0_en) begin
      chk("r0_addr", 64'(R0_addr), 64'(rexp));
      rexp = (rexp + 1) & 31;
    end
    if (out_valid && out_ready && !flush) begin
      if (sb_q.size() == 0) chk("pop_underflow", 64'd1, 64'd0);
      else begin
        exp_word = sb_q.pop_front();
        chk("out_data", out_data, exp_word);
      end
    end
    if (in_valid && in_ready) sb_q.push_back(d);
    if (fl) begin
      sb_q.delete(); wexp = 0; rexp = 0;
    end
  endtask

  task automatic run_table(input string tag);
    for (int i = 0; i < 11; i++) begin
      cycle(tbl[i].iv, 1'b1, 1'b0, tbl[i].din);
      chk($sformatf("%s v%0d in_ready", tag, i), 64'(in_ready), 64'd1);
      chk($sformatf("%s v%0d out_valid", tag, i), 64'(out_valid), 64'(tbl[i].e_ovld));
      if (tbl[i].e_ovld) chk($sformatf("%s v%0d out_data", tag, i), out_data, tbl[i].e_odata);
      chk($sformatf("%s v%0d level", tag, i), 64'(level), 64'(tbl[i].e_lvl));
      chk($sformatf("%s v%0d W0_en", tag, i), 64'(W0_en), 64'(tbl[i].e_wen));
      if (tbl[i].e_wen) chk($sformatf("%s v%0d W0_addr", tag, i), 64'(W0_addr), 64'(tbl[i].e_waddr));
      chk($sformatf("%s v%0d R0_en", tag, i), 64'(R0_en), 64'(tbl[i].e_ren));
      if (tbl[i].e_ren) chk($sformatf("%s v%0d R0_addr", tag, i), 64'(R0_addr), 64'(tbl[i].e_raddr));
    end
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (level != 6'd0 && n < 300) begin
      cycle(1'b0, 1'b1, 1'b0, 64'd0);
      n++;
    end
    chk({tag, " drain"}, 64'(level), 64'd0);
  endtask

  initial begin
    int pushed;
    int n;
    // Single-push latency, then two back-to-back pushes.
    tbl[0]  = mkv(1, 64'hA5A5, 0, 64'h0,    0, 1, 0, 0, 0);
    tbl[1]  = mkv(0, 64'h0,    0, 64'h0,    1, 0, 0, 1, 0);
    tbl[2]  = mkv(0, 64'h0,    0, 64'h0,    1, 0, 0, 0, 0);
    tbl[3]  = mkv(0, 64'h0,    1, 64'hA5A5, 1, 0, 0, 0, 0);
    tbl[4]  = mkv(0, 64'h0,    0, 64'h0,    0, 0, 0, 0, 0);
    tbl[5]  = mkv(1, 64'hB1,   0, 64'h0,    0, 1, 1, 0, 0);
    tbl[6]  = mkv(1, 64'hB2,   0, 64'h0,    1, 1, 2, 1, 1);
    tbl[7]  = mkv(0, 64'h0,    0, 64'h0,    2, 0, 0, 1, 2);
    tbl[8]  = mkv(0, 64'h0,    1, 64'hB1,   2, 0, 0, 0, 0);
    tbl[9]  = mkv(0, 64'h0,    1, 64'hB2,   1, 0, 0, 0, 0);
    tbl[10] = mkv(0, 64'h0,    0, 64'h0,    0, 0, 0, 0, 0);

    // Reset with requests active: everything must stay quiet.
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b1; out_ready = 1'b1; in_data = 64'h1234;
    repeat (3) @(negedge clk);
    #1;
    chk("rst in_ready", 64'(in_ready), 64'd0);
    chk("rst out_valid", 64'(out_valid), 64'd0);
    chk("rst W0_en", 64'(W0_en), 64'd0);
    chk("rst R0_en", 64'(R0_en), 64'd0);
    chk("rst level", 64'(level), 64'd0);
    @(negedge clk);
    rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b0;

    run_table("t1");

    // Fill to DEPTH+2 with the output stalled.
    for (int i = 0; i < 34; i++) begin
      cycle(1'b1, 1'b0, 1'b0, 64'(i));
      chk($sformatf("fill%0d in_ready", i), 64'(in_ready), 64'd1);
    end
    cycle(1'b1, 1'b0, 1'b0, 64'hDEAD);
    chk("full in_ready", 64'(in_ready), 64'd0);
    chk("full W0_en", 64'(W0_en), 64'd0);
    chk("full level", 64'(level), 64'd34);
    chk("full head", out_data, 64'd0);

    // Sustained push+pop at full occupancy.
    for (int i = 0; i < 100; i++) begin
      cycle(1'b1, 1'b1, 1'b0, 64'(1000 + i));
      chk("steady out_valid", 64'(out_valid), 64'd1);
      chk("steady level", 64'(level >= 6'd33 && level <= 6'd34), 64'd1);
    end
    drain("steady");

    // Random traffic, 2000 accepted words.
    pushed = 0; n = 0;
    while (pushed < 2000 && n < 20000) begin
      cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, {$urandom, $urandom});
      if (in_valid && in_ready) pushed++;
      n++;
    end
    chk("random pushed", 64'(pushed), 64'd2000);
    drain("random");

    // Flush while a read returns.
    cycle(1'b1, 1'b0, 1'b0, 64'hF0);
    cycle(1'b1, 1'b0, 1'b0, 64'hF1);
    chk("pre_flush R0_en", 64'(R0_en), 64'd1);
    cycle(1'b1, 1'b0, 1'b1, 64'hF2);
    chk("flush in_ready", 64'(in_ready), 64'd0);
    chk("flush W0_en", 64'(W0_en), 64'd0);
    chk("flush R0_en", 64'(R0_en), 64'd0);
    cycle(1'b0, 1'b1, 1'b0, 64'd0);
    chk("post_flush level", 64'(level), 64'd0);
    chk("post_flush out_valid", 64'(out_valid), 64'd0);
    cycle(1'b0, 1'b1, 1'b0, 64'd0);
    chk("post_flush stale", 64'(out_valid), 64'd0);
    cycle(1'b1, 1'b1, 1'b0, 64'hF3);
    chk("post_flush W0_addr", 64'(W0_addr), 64'd0);
    cycle(1'b0, 1'b1, 1'b0, 64'd0);
    chk("post_flush R0_addr", 64'({R0_en, R0_addr}), 64'h20);
    cycle(1'b0, 1'b1, 1'b0, 64'd0);
    cycle(1'b0, 1'b1, 1'b0, 64'd0);
    chk("post_flush out", out_data, 64'hF3);
    drain("flush");

    // Asynchronous reset mid-stream with buf_cnt=2, mem_cnt=5.
    for (int i = 0; i < 7; i++) cycle(1'b1, 1'b0, 1'b0, 64'(200 + i));
    repeat (3) cycle(1'b0, 1'b0, 1'b0, 64'd0);
    chk("pre_rst level", 64'(level), 64'd7);
    @(negedge clk);
    in_valid = 1'b1; out_ready = 1'b1; in_data = 64'h77;
    #1;
    chk("pre_rst in_ready", 64'(in_ready), 64'd1);
    chk("pre_rst R0_en", 64'(R0_en), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async out_valid", 64'(out_valid), 64'd0);
    chk("async in_ready", 64'(in_ready), 64'd0);
    chk("async W0_en", 64'(W0_en), 64'd0);
    chk("async R0_en", 64'(R0_en), 64'd0);
    chk("async level", 64'(level), 64'd0);
    sb_q.delete(); wexp = 0; rexp = 0;
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b0;
    rst_n = 1'b1;
    run_table("t2");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_1r1w_fifo_ctrl.md
Name: mem_1r1w_fifo_ctrl

Overview:
- Single-clock FIFO controller that drives an external 1R1W synchronous-read memory macro (32x64, read latency 1, mem_1r1w-style W0_*/R0_* ports).
- Exposes valid/ready push and pop interfaces with first-word-fall-through output.
- Hides the one-cycle read latency behind a 2-entry output prefetch buffer.
- The parent instantiates the memory next to this block and ties W0_clk/R0_clk to clk.

Parameters:
- DEPTH, 32, memory words; power of two, >= 4
- WIDTH, 64, data bits per word
- ADDR_W, $clog2(DEPTH) = 5, memory address width
- LVL_W, $clog2(DEPTH+3) = 6, width of level output

Ports:
- clk  in  1  sole clock; memory W0_clk/R0_clk tied to it by parent
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous clear of all contents
- in_valid  in  1  push request
- in_ready  out  1  push accept
- in_data  in  WIDTH  push data
- out_valid  out  1  head word available
- out_ready  in  1  pop request
- out_data  out  WIDTH  head word
- level  out  LVL_W  total words held (memory + in flight + buffer)
- W0_addr  out  ADDR_W  memory write address
- W0_en  out  1  memory write enable
- W0_data  out  WIDTH  memory write data
- R0_addr  out  ADDR_W  memory read address
- R0_en  out  1  memory read enable
- R0_data  in  WIDTH  memory read data, valid the cycle after R0_en

Behaviour:
- State registers: wptr, rptr (ADDR_W, wrap mod DEPTH), mem_cnt (0..DEPTH), rd_inflight (1b), out buffer of 2 entries with buf_cnt (0..2) and head index.
- Reset (rst_n low, async): all state registers = 0. While reset is asserted, in_ready=0, out_valid=0, W0_en=0, R0_en=0, level=0.
- Push:
  - in_ready = (mem_cnt != DEPTH) & !flush.
  - push = in_valid & in_ready.
  - On push: W0_en=1, W0_addr=wptr, W0_data=in_data; wptr++; mem_cnt++.
  - W0_en is combinational from push; there is no write without push.
- Pop:
  - out_valid = (buf_cnt != 0); out_data = buffer head.
  - pop = out_valid & out_ready & !flush. On pop: head advances and buf_cnt decrements.
- Read issue:
  - issue = (mem_cnt != 0) & ((buf_cnt + rd_inflight - pop) < 2) & !flush.
  - On issue: R0_en=1, R0_addr=rptr; rptr++; mem_cnt--; rd_inflight set for the next cycle.
  - The cycle after an issue, R0_data is written into the buffer tail and buf_cnt increments.
  - Same-cycle capture and pop are both applied.
- mem_cnt update: next = mem_cnt + push - issue, applied together.
  - A word written in cycle t is first readable in cycle t+1, so read and write never hit the same address in one cycle.
- Latency: push in cycle 0 into an empty FIFO -> R0_en in cycle 1 -> captured end of cycle 2 -> out_valid in cycle 3.
- Throughput: with out_ready held high, one pop per cycle is sustained indefinitely.
- Capacity is DEPTH+2 words: when the buffer is full, in_ready stays high until mem_cnt = DEPTH.
- level = mem_cnt + rd_inflight + buf_cnt, registered-state derived, no combinational term from in_valid/out_ready.
- Full with simultaneous push and issue: push is blocked by in_ready=0 that cycle even if an issue frees a slot. There is no same-cycle full bypass.
- flush (priority over all):
  - Next state: all pointers, counts and rd_inflight = 0.
  - Data returning on R0_data the cycle after a flush is discarded.
  - W0_en=0 and R0_en=0 during the flush cycle.
- Pointer wrap: DEPTH-1 -> 0. No overflow or underflow is possible by construction. Assertions check mem_cnt <= DEPTH and buf_cnt <= 2.

Decomposition:
- Package mem_fifo_pkg holds:
  - DEPTH_DEFAULT=32 and WIDTH_DEFAULT=64
  - function addr_w(depth)
  - function lvl_w(depth)
- Sub-module fifo_prefetch_buf: 2-entry first-word-fall-through buffer.
  - Inputs: capture strobe and data, pop.
  - Outputs: buf_cnt, head data.
  - The top level keeps the pointers, mem_cnt, issue logic and flush.

Test Plan:
- Reset then single push 0xA5A5 at cycle 0, out_ready=1 -> R0_en at cycle 1 with R0_addr=0; out_valid=1 with out_data=0xA5A5 at cycle 3; level returns to 0 after the pop.
- Push 34 words (0..33) with out_ready=0 -> in_ready drops after word 33; level=34; W0_addr wraps 31->0 only after pops free slots.
- Fill to 34, then push and pop continuously for 100 cycles -> one pop per cycle, in-order data, level constant at 34 +/-1, pointers wrap cleanly.
- Random in_valid/out_ready (50%) over 2000 words -> scoreboard order matches; R0_addr never equals W0_addr while both enables are high; level never exceeds 34.
- Issue a read, then assert flush the next cycle while R0_data returns -> level=0 and out_valid=0 the cycle after; the stale word never appears; the next push reads from address 0.
- Drop rst_n asynchronously mid-stream (buf_cnt=2, mem_cnt=5) -> out_valid, in_ready, W0_en and R0_en go to 0 immediately; after release, behaviour equals post-reset.
